// File: rtl/bsg_fpu_sticky_shift_iter.sv
// bsg_fpu_sticky_shift_iter
//   Multi-cycle right shifter with sticky-bit accumulation for FPU mantissa
//   alignment. An accepted operand is shifted right by min(shamt_i, width_p)
//   in chunks of at most step_p bits per cycle. Every bit shifted out is ORed
//   into a sticky flag.
//
// Handshake:
//   Input side is valid/ready. A transfer happens on a rising edge where
//   v_i & ready_o. ready_o is high only in IDLE and never during reset.
//   Output side is valid/yumi. The result is held stable while v_o=1 and
//   is released on the edge where yumi_i=1. yumi_i must only be raised while
//   v_o=1.
//
// Ports:
//   clk_i      clock
//   reset_n_i  synchronous active-low reset
//   v_i        input valid
//   ready_o    block can accept an operand (IDLE only)
//   data_i     operand to shift
//   shamt_i    right-shift amount (saturated at width_p)
//   v_o        result valid (DONE only)
//   yumi_i     consumer takes the result
//   data_o     data_i >> min(shamt_i, width_p)
//   sticky_o   OR of every bit shifted out
//   state_o    debug view of the FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Configuration:
//   BSG_FPU_STICKY_SHIFT_ITER_EARLY_EXIT_EN
//     When defined, SHIFT finishes as soon as the shifted data becomes zero.
//     Results are unchanged; only latency shrinks.

module bsg_fpu_sticky_shift_iter #(
  parameter int width_p       = 32,
  parameter int shamt_width_p = $clog2(width_p) + 1,
  parameter int step_p        = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  output logic                     ready_o,
  input  logic [width_p-1:0]       data_i,
  input  logic [shamt_width_p-1:0] shamt_i,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [width_p-1:0]       data_o,
  output logic                     sticky_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [shamt_width_p-1:0] step_lp  = shamt_width_p'(step_p);
  localparam logic [shamt_width_p-1:0] width_lp = shamt_width_p'(width_p);
  localparam logic [width_p-1:0]       ones_lp  = '1;

  state_e                     state_r, state_n;
  logic [width_p-1:0]         data_r, data_n;
  logic                       sticky_r, sticky_n;
  logic [shamt_width_p-1:0]   rem_r, rem_n;
  logic [width_p-1:0]         data_o_r;
  logic                       sticky_o_r;

  // One shift step, computed every cycle and used only in SHIFT.
  logic [shamt_width_p-1:0]   step_k;
  logic [width_p-1:0]         step_mask;
  logic [width_p-1:0]         step_data;
  logic                       step_sticky;
  logic [shamt_width_p-1:0]   step_rem;
  logic [shamt_width_p-1:0]   load_rem;
  logic                       load_out;

  always_comb begin
    step_k      = (rem_r < step_lp) ? rem_r : step_lp;
    // Low step_k bits are the ones about to fall off the bottom. For
    // step_k == width_p the shift yields zero and the mask covers everything.
    step_mask   = ~(ones_lp << step_k);
    step_data   = data_r >> step_k;
    step_sticky = sticky_r | (|(data_r & step_mask));
    step_rem    = rem_r - step_k;
    load_rem    = (shamt_i >= width_lp) ? width_lp : shamt_i;
  end

  always_comb begin
    state_n  = state_r;
    data_n   = data_r;
    sticky_n = sticky_r;
    rem_n    = rem_r;

    unique case (state_r)
      IDLE: begin
        if (v_i) begin
          data_n   = data_i;
          sticky_n = 1'b0;
          rem_n    = load_rem;
          state_n  = (load_rem == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_n   = step_data;
        sticky_n = step_sticky;
        rem_n    = step_rem;
        if (step_rem == '0) begin
          state_n = DONE;
        end
`ifdef BSG_FPU_STICKY_SHIFT_ITER_EARLY_EXIT_EN
        // Once the data is all zero, further shifting changes nothing.
        if (step_data == '0) begin
          rem_n   = '0;
          state_n = DONE;
        end
`endif
      end
      DONE: begin
        if (yumi_i) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Output registers only change on entry to DONE so data_o/sticky_o keep
    // the previous result through IDLE and SHIFT.
    load_out = (state_n == DONE) && (state_r != DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      data_r     <= '0;
      sticky_r   <= 1'b0;
      rem_r      <= '0;
      data_o_r   <= '0;
      sticky_o_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      data_r   <= data_n;
      sticky_r <= sticky_n;
      rem_r    <= rem_n;
      if (load_out) begin
        data_o_r   <= data_n;
        sticky_o_r <= sticky_n;
      end
    end
  end

  assign ready_o  = (state_r == IDLE) && reset_n_i;
  assign v_o      = (state_r == DONE);
  assign data_o   = data_o_r;
  assign sticky_o = sticky_o_r;
  assign state_o  = state_r;

`ifndef SYNTHESIS
  yumi_only_when_valid: assert property (
    @(posedge clk_i) disable iff (!reset_n_i) (yumi_i |-> v_o)
  );
`endif

endmodule
